// File: rtl/phase_calc_array.sv
// phase_calc_array: per-channel phase difference between a reference neuron
// output (nf) and each measured neuron output (ns[i]), counted in clk cycles
// from an nf rising edge to the next ns[i] rising edge, saturating at 2^W-1.
module phase_calc_array #(
    parameter int unsigned N           = 4,
    parameter int unsigned W           = 4,
    parameter bit          CHANGE_ONLY = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           nf,
    input  logic [N-1:0]   ns,
    output logic [N*W-1:0] phase_diff,
    output logic [N-1:0]   pd_valid,
    output logic [N-1:0]   pd_ovf,
    output logic [N-1:0]   busy
);

    localparam logic [W-1:0] SAT = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    logic         nf_q;
    logic [N-1:0] ns_q;
    logic         nf_rise;
    logic [N-1:0] ns_rise;

    assign nf_rise = nf & ~nf_q;
    assign ns_rise = ns & ~ns_q;

    // Edge-detect history; runs regardless of en so no stale edge appears on re-enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nf_q <= 1'b0;
            ns_q <= '0;
        end else begin
            nf_q <= nf;
            ns_q <= ns;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t       state, state_n;
        logic [W-1:0] cnt, cnt_n;
        logic [W-1:0] res, res_n;
        logic         ovf, ovf_n;
        logic         vld, vld_n;
        logic         seen, seen_n;
        logic [W-1:0] cnt_sat;
        logic         cap;
        logic [W-1:0] cap_val;
        logic         cap_ovf;

        // Next-state, counter and capture logic for this channel
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            res_n   = res;
            ovf_n   = ovf;
            seen_n  = seen;
            vld_n   = 1'b0;
            cap     = 1'b0;
            cap_val = '0;
            cap_ovf = 1'b0;
            cnt_sat = (cnt == SAT) ? SAT : cnt + W'(1);

            if (!en) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else if (state == IDLE) begin
                if (nf_rise && ns_rise[i]) begin
                    // Zero phase: capture immediately without entering COUNT
                    cap = 1'b1;
                end else if (nf_rise) begin
                    state_n = COUNT;
                    cnt_n   = '0;
                end
            end else begin
                if (ns_rise[i]) begin
                    cap     = 1'b1;
                    cap_val = cnt_sat;
                    cap_ovf = (cnt >= SAT - W'(1));
                    // A coincident reference edge starts the next measurement
                    state_n = nf_rise ? COUNT : IDLE;
                    cnt_n   = '0;
                end else if (nf_rise) begin
                    // Missed period: restart without a capture
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_sat;
                end
            end

            if (cap) begin
                res_n  = cap_val;
                ovf_n  = cap_ovf;
                seen_n = 1'b1;
                vld_n  = CHANGE_ONLY ? (!seen || cap_val != res || cap_ovf != ovf) : 1'b1;
            end
        end

        // Channel state and result registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
                res   <= '0;
                ovf   <= 1'b0;
                vld   <= 1'b0;
                seen  <= 1'b0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
                res   <= res_n;
                ovf   <= ovf_n;
                vld   <= vld_n;
                seen  <= seen_n;
            end
        end

        assign phase_diff[i*W +: W] = res;
        assign pd_ovf[i]            = ovf;
        assign pd_valid[i]          = vld;
        assign busy[i]              = (state == COUNT);
    end

endmodule

// File: tb/tb_phase_calc_array.sv
// Directed bench for phase_calc_array with a scoreboard of expected captures.
module tb_phase_calc_array;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           nf;
    logic [N-1:0]   ns;
    logic [N*W-1:0] phase_diff,  phase_diff0;
    logic [N-1:0]   pd_valid,    pd_valid0;
    logic [N-1:0]   pd_ovf,      pd_ovf0;
    logic [N-1:0]   busy,        busy0;

    phase_calc_array #(.N(N), .W(W), .CHANGE_ONLY(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .nf(nf), .ns(ns),
        .phase_diff(phase_diff), .pd_valid(pd_valid), .pd_ovf(pd_ovf), .busy(busy)
    );

    phase_calc_array #(.N(N), .W(W), .CHANGE_ONLY(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .nf(nf), .ns(ns),
        .phase_diff(phase_diff0), .pd_valid(pd_valid0), .pd_ovf(pd_ovf0), .busy(busy0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int val;
        int ovf;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   held_val[N];
    int   held_ovf[N];
    bit   seen_m[N];
    int   pulses0 = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pd_of(input logic [N*W-1:0] v, input int ch);
        logic [N*W-1:0] t;
        t = v >> (ch * W);
        return int'(t[W-1:0]);
    endfunction

    // Model of a capture of delay d on channel ch; pushes only when a pulse is due
    function automatic void expect_cap(input int ch, input int d);
        int val;
        int ovf;
        val = (d > 15) ? 15 : d;
        ovf = (d >= 15) ? 1 : 0;
        if (!seen_m[ch] || val != held_val[ch] || ovf != held_ovf[ch]) begin
            exp_t e;
            e.ch = ch; e.val = val; e.ovf = ovf;
            sbq.push_back(e);
        end
        seen_m[ch]   = 1'b1;
        held_val[ch] = val;
        held_ovf[ch] = ovf;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            seen_m[i] = 1'b0; held_val[i] = 0; held_ovf[i] = 0;
        end
    endfunction

    // One reference period: nf rises, channel i rises d_i cycles later (-1 = never)
    task automatic period(input int d0, input int d1, input int d2, input int d3);
        int d[N];
        int maxd;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        maxd = 0;
        for (int i = 0; i < N; i++) if (d[i] > maxd) maxd = d[i];
        @(negedge clk);
        nf = 1'b1;
        ns = '0;
        for (int i = 0; i < N; i++) if (d[i] == 0) begin ns[i] = 1'b1; expect_cap(i, 0); end
        for (int t = 1; t <= maxd; t++) begin
            @(negedge clk);
            nf = 1'b0;
            ns = '0;
            for (int i = 0; i < N; i++) if (d[i] == t) begin ns[i] = 1'b1; expect_cap(i, t); end
        end
        @(negedge clk);
        nf = 1'b0;
        ns = '0;
        repeat (2) @(negedge clk);
    endtask

    // Force every channel back to IDLE
    task automatic idle_all();
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
    endtask

    // Monitor: every pd_valid pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < N; ch++) begin
                if (pd_valid[ch]) begin
                    if (sbq.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_valid: ch %0d value %0d ovf %0d at %0t",
                                 ch, pd_of(phase_diff, ch), pd_ovf[ch], $time);
                    end else begin
                        mon_e = sbq.pop_front();
                        check("sb_channel", ch, mon_e.ch);
                        check("sb_value", pd_of(phase_diff, ch), mon_e.val);
                        check("sb_ovf", int'(pd_ovf[ch]), mon_e.ovf);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && pd_valid0[0]) pulses0++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; nf = 1'b0; ns = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_phase_diff", int'(phase_diff), 0);
        check("rst_pd_valid",   int'(pd_valid),   0);
        check("rst_pd_ovf",     int'(pd_ovf),     0);
        check("rst_busy",       int'(busy),       0);
        rst = 1'b0;

        // ns edges without a reference edge are ignored
        repeat (3) begin
            @(negedge clk); ns = '1;
            @(negedge clk); ns = '0;
            @(negedge clk);
            check("idle_busy", int'(busy), 0);
        end

        // Basic delays
        period(5, -1, 9, -1);
        check("basic_ch0", pd_of(phase_diff, 0), 5);
        check("basic_ch2", pd_of(phase_diff, 2), 9);
        check("basic_ch1", pd_of(phase_diff, 1), 0);
        check("basic_ch3", pd_of(phase_diff, 3), 0);
        check("basic_ovf", int'(pd_ovf), 0);
        idle_all();

        // Zero phase on channel 1
        @(negedge clk);
        nf = 1'b1; ns = 4'b0010; expect_cap(1, 0);
        @(negedge clk);
        nf = 1'b0; ns = '0;
        check("zero_busy1", int'(busy[1]), 0);
        check("zero_busy0", int'(busy[0]), 1);
        @(negedge clk);
        check("zero_ch1", pd_of(phase_diff, 1), 0);
        check("zero_busy1_later", int'(busy[1]), 0);
        idle_all();

        // Saturation then recovery
        period(-1, -1, -1, 20);
        check("sat_ch3", pd_of(phase_diff, 3), 15);
        check("sat_ovf3", int'(pd_ovf[3]), 1);
        period(-1, -1, -1, 3);
        check("unsat_ch3", pd_of(phase_diff, 3), 3);
        check("unsat_ovf3", int'(pd_ovf[3]), 0);
        idle_all();

        // Change-only suppression vs every-capture strobing
        pulses0 = 0;
        period(6, -1, -1, -1);
        period(6, -1, -1, -1);
        period(7, -1, -1, -1);
        check("every_capture_pulses", pulses0, 3);
        check("every_capture_ch0", pd_of(phase_diff0, 0), 7);
        check("change_only_ch0", pd_of(phase_diff, 0), 7);
        idle_all();

        // Reference restart drops the first period
        @(negedge clk); nf = 1'b1;
        @(negedge clk); nf = 1'b0;
        repeat (2) @(negedge clk);
        nf = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            nf = 1'b0;
            ns = '0;
            if (t == 4) begin ns[2] = 1'b1; expect_cap(2, 4); end
        end
        @(negedge clk); ns = '0;
        repeat (2) @(negedge clk);
        check("restart_ch2", pd_of(phase_diff, 2), 4);
        idle_all();

        // Enable drop mid-COUNT
        @(negedge clk); nf = 1'b1;
        @(negedge clk); nf = 1'b0;
        repeat (2) @(negedge clk);
        check("en_busy_before", int'(busy[0]), 1);
        en = 1'b0;
        @(negedge clk);
        check("en_busy_off", int'(busy), 0);
        ns = 4'b0001;
        @(negedge clk); ns = '0;
        @(negedge clk); en = 1'b1;
        repeat (3) @(negedge clk);
        check("en_hold_ch0", pd_of(phase_diff, 0), 7);
        check("en_busy_after", int'(busy), 0);

        // Asynchronous reset mid-COUNT
        @(negedge clk); nf = 1'b1;
        @(negedge clk); nf = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_phase_diff", int'(phase_diff), 0);
        check("arst_pd_ovf",     int'(pd_ovf),     0);
        check("arst_busy",       int'(busy),       0);
        check("arst_pd_valid",   int'(pd_valid),   0);
        model_reset();
        @(negedge clk); rst = 1'b0;
        period(-1, 0, 2, -1);
        check("post_rst_ch2", pd_of(phase_diff, 2), 2);

        repeat (3) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
